// File: rtl/nubus_sram_pkg.sv
// Shared types and defaults for the NuBus SRAM controller.
// Optional parity (NUBUS_SRAM_PARITY_EN) is configured in nubus_sram_ctrl.
package nubus_sram_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETUP   = 3'd1,
      S_ACCESS  = 3'd2,
      S_DONE    = 3'd3,
      S_RELEASE = 3'd4
   } state_e;

   localparam int WAIT_RD_DEF = 2;
   localparam int WAIT_WR_DEF = 2;
   localparam int CNT_W       = 4;

   function automatic logic even_par8(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/nubus_sram_parity.sv
// Per-byte even parity: generates write parity and checks read data against sram_dqp_i.
// Only instantiated when NUBUS_SRAM_PARITY_EN is defined.
module nubus_sram_parity
   import nubus_sram_pkg::*;
(
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   input  logic [3:0]  dqp_i,
   output logic [3:0]  dqp_o,
   output logic        err
);

   logic [3:0] rd_par;

   always_comb begin
      dqp_o  = '0;
      rd_par = '0;
      for (int i = 0; i < 4; i++) begin
         dqp_o[i]  = even_par8(wdata[8*i +: 8]);
         rd_par[i] = even_par8(rdata[8*i +: 8]);
      end
   end

   assign err = |(rd_par ^ dqp_i);

endmodule

// File: rtl/nubus_sram_ctrl.sv
// NuBus slave-side asynchronous SRAM controller: one request per IDLE..RELEASE pass.
// Define NUBUS_SRAM_PARITY_EN to enable per-byte even parity on the SRAM bus.
module nubus_sram_ctrl
   import nubus_sram_pkg::*;
#(
   parameter int ADDR_W  = 18,
   parameter int WAIT_RD = WAIT_RD_DEF,
   parameter int WAIT_WR = WAIT_WR_DEF
) (
   input  logic              mem_clk,
   input  logic              mem_reset,
   input  logic              mem_valid,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   input  logic [3:0]        mem_wstrb,
   input  logic              mem_myslot,
   input  logic              mem_myexp,
   output logic              mem_ready,
   output logic [31:0]       mem_rdata,
   output logic              mem_parerr,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_dq_o,
   input  logic [31:0]       sram_dq_i,
   output logic              sram_dq_oe,
   output logic [3:0]        sram_dqp_o,
   input  logic [3:0]        sram_dqp_i,
   output logic              sram_cen,
   output logic              sram_wen,
   output logic              sram_oen,
   output logic [3:0]        sram_ben,
   output state_e            dbg_state
);

   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(WAIT_RD - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WAIT_WR - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              is_wr_q, is_wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       dq_o_q, dq_o_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [3:0]        ben_q, ben_d;
   logic [3:0]        dqp_o_q, dqp_o_d;
   logic              cen_q, cen_d, wen_q, wen_d, oen_q, oen_d;
   logic              dq_oe_q, dq_oe_d, ready_q, ready_d, parerr_q, parerr_d;
   logic              active;
   logic [3:0]        par_gen;
   logic              par_err;
   logic              unused_ok;

`ifdef NUBUS_SRAM_PARITY_EN
   nubus_sram_parity u_parity (
      .wdata (mem_wdata),
      .rdata (sram_dq_i),
      .dqp_i (sram_dqp_i),
      .dqp_o (par_gen),
      .err   (par_err)
   );
   assign unused_ok = ^{mem_myexp, mem_addr[31:ADDR_W+2], mem_addr[1:0]};
`else
   assign par_gen   = 4'b0000;
   assign par_err   = 1'b0;
   assign unused_ok = ^{mem_myexp, mem_addr[31:ADDR_W+2], mem_addr[1:0], sram_dqp_i};
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_wr_d  = is_wr_q;
      addr_d   = addr_q;
      dq_o_d   = dq_o_q;
      rdata_d  = rdata_q;
      ben_d    = ben_q;
      dqp_o_d  = dqp_o_q;
      parerr_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mem_valid && mem_myslot) begin
               state_d = S_SETUP;
               is_wr_d = |mem_wstrb;
               addr_d  = mem_addr[ADDR_W+1:2];
               ben_d   = (|mem_wstrb) ? ~mem_wstrb : 4'b0000;
               if (|mem_wstrb) begin
                  dq_o_d  = mem_wdata;
                  dqp_o_d = par_gen;
               end
            end
         end
         S_SETUP: begin
            state_d = S_ACCESS;
            cnt_d   = is_wr_q ? WR_LOAD : RD_LOAD;
         end
         S_ACCESS: begin
            if (cnt_q == '0) begin
               state_d = S_DONE;
               if (!is_wr_q) begin
                  rdata_d  = sram_dq_i;
                  parerr_d = par_err;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DONE:    state_d = S_RELEASE;
         // Held requests park here so they are not re-accepted.
         S_RELEASE: if (!mem_valid) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      // Strobes are registered from the next state so they align with it.
      active  = (state_d == S_SETUP) || (state_d == S_ACCESS) || (state_d == S_DONE);
      cen_d   = !active;
      oen_d   = !(active && !is_wr_d);
      wen_d   = !((state_d == S_ACCESS) && is_wr_d);
      dq_oe_d = active && is_wr_d;
      ready_d = (state_d == S_DONE);
      if (!active) ben_d = 4'hF;
   end

   always_ff @(posedge mem_clk) begin
      if (mem_reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         is_wr_q  <= 1'b0;
         addr_q   <= '0;
         dq_o_q   <= '0;
         rdata_q  <= '0;
         ben_q    <= 4'hF;
         dqp_o_q  <= '0;
         cen_q    <= 1'b1;
         wen_q    <= 1'b1;
         oen_q    <= 1'b1;
         dq_oe_q  <= 1'b0;
         ready_q  <= 1'b0;
         parerr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_wr_q  <= is_wr_d;
         addr_q   <= addr_d;
         dq_o_q   <= dq_o_d;
         rdata_q  <= rdata_d;
         ben_q    <= ben_d;
         dqp_o_q  <= dqp_o_d;
         cen_q    <= cen_d;
         wen_q    <= wen_d;
         oen_q    <= oen_d;
         dq_oe_q  <= dq_oe_d;
         ready_q  <= ready_d;
         parerr_q <= parerr_d;
      end
   end

   assign mem_ready  = ready_q;
   assign mem_rdata  = rdata_q;
   assign mem_parerr = parerr_q;
   assign sram_addr  = addr_q;
   assign sram_dq_o  = dq_o_q;
   assign sram_dq_oe = dq_oe_q;
   assign sram_dqp_o = dqp_o_q;
   assign sram_cen   = cen_q;
   assign sram_wen   = wen_q;
   assign sram_oen   = oen_q;
   assign sram_ben   = ben_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_nubus_sram_ctrl.sv
// Directed bench for nubus_sram_ctrl with a small byte-enabled SRAM model.
// Parity expectations follow NUBUS_SRAM_PARITY_EN.
module tb_nubus_sram_ctrl;
   import nubus_sram_pkg::*;

   logic        mem_clk = 1'b0;
   logic        mem_reset = 1'b1;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic        mem_myslot = 1'b0;
   logic        mem_myexp = 1'b0;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_parerr;
   logic [17:0] sram_addr;
   logic [31:0] sram_dq_o;
   logic [31:0] sram_dq_i;
   logic        sram_dq_oe;
   logic [3:0]  sram_dqp_o;
   logic [3:0]  sram_dqp_i;
   logic        sram_cen, sram_wen, sram_oen;
   logic [3:0]  sram_ben;
   state_e      dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   nubus_sram_ctrl dut (
      .mem_clk(mem_clk), .mem_reset(mem_reset), .mem_valid(mem_valid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_myslot(mem_myslot), .mem_myexp(mem_myexp), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .mem_parerr(mem_parerr), .sram_addr(sram_addr),
      .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
      .sram_dqp_o(sram_dqp_o), .sram_dqp_i(sram_dqp_i), .sram_cen(sram_cen),
      .sram_wen(sram_wen), .sram_oen(sram_oen), .sram_ben(sram_ben),
      .dbg_state(dbg_state)
   );

   always #5 mem_clk = ~mem_clk;

   // SRAM model: 16 words, byte-enabled writes, cleared by mem_reset.
   logic [31:0] mem [0:15];
   logic        flip_p2 = 1'b0;
   logic [31:0] rd_word;

   always @(posedge mem_clk) begin
      if (mem_reset) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else if (!sram_cen && !sram_wen) begin
         for (int b = 0; b < 4; b++)
            if (!sram_ben[b]) mem[sram_addr[3:0]][8*b +: 8] <= sram_dq_o[8*b +: 8];
      end
   end

   assign rd_word    = mem[sram_addr[3:0]];
   assign sram_dq_i  = (!sram_cen && !sram_oen) ? rd_word : 32'h0;
   assign sram_dqp_i = {^rd_word[31:24], ^rd_word[23:16] ^ flip_p2, ^rd_word[15:8], ^rd_word[7:0]};

   // Observations of the most recent run_req.
   int          rdy_n, rdy_edge, wen_n, oen_n, cen_n, acc_n, bad_n;
   logic [3:0]  ben_w, dqp_w;
   logic [17:0] addr_a;
   logic [31:0] rdata_r;
   logic        perr_r;

   // hold >= 0: keep mem_valid high that many cycles after mem_ready; hold < 0: drop it mid-access.
   task automatic run_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int hold);
      int   post;
      logic seen, prev_cen;
      rdy_n = 0; rdy_edge = -1; wen_n = 0; oen_n = 0; cen_n = 0; acc_n = 0; bad_n = 0;
      ben_w = 4'hx; dqp_w = 4'hx; addr_a = 'x; rdata_r = 'x; perr_r = 1'bx;
      post = 0; seen = 1'b0; prev_cen = 1'b1;
      mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_myslot = 1'b1; mem_valid = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge mem_clk); #1;
         if (mem_ready) begin
            rdy_n++; rdy_edge = k + 1; rdata_r = mem_rdata; perr_r = mem_parerr; seen = 1'b1;
         end
         if (!sram_wen) begin wen_n++; ben_w = sram_ben; dqp_w = sram_dqp_o; end
         if (!sram_oen) oen_n++;
         if (!sram_cen) begin cen_n++; addr_a = sram_addr; end
         if (!sram_cen && prev_cen) acc_n++;
         prev_cen = sram_cen;
         if ((!sram_wen && !sram_oen) || (sram_dq_oe && !sram_oen)) bad_n++;
         if (hold < 0 && k == 1) mem_valid = 1'b0;
         if (seen && mem_valid) begin
            if (post >= hold) mem_valid = 1'b0;
            post++;
         end
         if (seen && !mem_valid && dbg_state == S_IDLE) break;
      end
      mem_valid = 1'b0; mem_myslot = 1'b0; mem_wstrb = 4'h0;
   endtask

   task automatic test_reset();
      n_tests++;
      if ({mem_ready, mem_parerr, mem_rdata} !== 34'h0) begin
         n_fail++; $display("FAIL reset_resp: got %h expected 0", {mem_ready, mem_parerr, mem_rdata});
      end
      n_tests++;
      if ({sram_cen, sram_wen, sram_oen, sram_ben, sram_dq_oe} !== 8'b1111_1110) begin
         n_fail++; $display("FAIL reset_strobes: got %b expected 11111110", {sram_cen, sram_wen, sram_oen, sram_ben, sram_dq_oe});
      end
      n_tests++;
      if ({sram_addr, sram_dq_o, sram_dqp_o} !== 54'h0) begin
         n_fail++; $display("FAIL reset_bus: got %h expected 0", {sram_addr, sram_dq_o, sram_dqp_o});
      end
      n_tests++;
      if (dbg_state !== S_IDLE) begin
         n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE);
      end
   endtask

   task automatic test_write();
      logic [3:0] exp_dqp;
`ifdef NUBUS_SRAM_PARITY_EN
      exp_dqp = 4'b0010;
`else
      exp_dqp = 4'b0000;
`endif
      run_req(32'hF000_0000, 32'h8765_4321, 4'hF, 0);
      n_tests++;
      if (wen_n !== 2) begin n_fail++; $display("FAIL wr_wen_cycles: got %0d expected 2", wen_n); end
      n_tests++;
      if (rdy_n !== 1 || rdy_edge !== 4) begin
         n_fail++; $display("FAIL wr_ready: got n=%0d edge=%0d expected n=1 edge=4", rdy_n, rdy_edge);
      end
      n_tests++;
      if (addr_a !== 18'h0 || ben_w !== 4'h0) begin
         n_fail++; $display("FAIL wr_addr_ben: got %h/%b expected 0/0000", addr_a, ben_w);
      end
      n_tests++;
      if (oen_n !== 0 || cen_n !== 4 || bad_n !== 0) begin
         n_fail++; $display("FAIL wr_strobes: got oen=%0d cen=%0d bad=%0d expected 0 4 0", oen_n, cen_n, bad_n);
      end
      n_tests++;
      if (dqp_w !== exp_dqp) begin n_fail++; $display("FAIL wr_dqp: got %b expected %b", dqp_w, exp_dqp); end
      n_tests++;
      if (mem[0] !== 32'h8765_4321) begin n_fail++; $display("FAIL wr_model: got %h expected 87654321", mem[0]); end
   endtask

   task automatic test_read();
      run_req(32'hF000_0000, 32'h0, 4'h0, 0);
      n_tests++;
      if (rdata_r !== 32'h8765_4321 || mem_rdata !== 32'h8765_4321) begin
         n_fail++; $display("FAIL rd_data: got %h/%h expected 87654321", rdata_r, mem_rdata);
      end
      n_tests++;
      if (rdy_n !== 1 || rdy_edge !== 4) begin
         n_fail++; $display("FAIL rd_ready: got n=%0d edge=%0d expected n=1 edge=4", rdy_n, rdy_edge);
      end
      n_tests++;
      if (oen_n !== 4 || wen_n !== 0 || bad_n !== 0) begin
         n_fail++; $display("FAIL rd_strobes: got oen=%0d wen=%0d bad=%0d expected 4 0 0", oen_n, wen_n, bad_n);
      end
      n_tests++;
      if (perr_r !== 1'b0) begin n_fail++; $display("FAIL rd_parerr: got %b expected 0", perr_r); end
   endtask

   task automatic test_byte_write();
      run_req(32'hF000_0004, 32'h8765_4321, 4'b0001, 0);
      n_tests++;
      if (ben_w !== 4'b1110 || addr_a !== 18'h1) begin
         n_fail++; $display("FAIL byte_ben: got %b/%h expected 1110/1", ben_w, addr_a);
      end
      run_req(32'hF000_0004, 32'h0, 4'h0, 0);
      n_tests++;
      if (rdata_r !== 32'h0000_0021) begin n_fail++; $display("FAIL byte_readback: got %h expected 00000021", rdata_r); end
      n_tests++;
      if (sram_ben !== 4'hF) begin n_fail++; $display("FAIL byte_ben_idle: got %b expected 1111", sram_ben); end
   endtask

   task automatic test_hold_valid();
      int act;
      run_req(32'hF000_0004, 32'h0, 4'h0, 10);
      n_tests++;
      if (acc_n !== 1 || rdy_n !== 1) begin
         n_fail++; $display("FAIL hold_single: got acc=%0d rdy=%0d expected 1 1", acc_n, rdy_n);
      end
      n_tests++;
      if (rdata_r !== 32'h0000_0021) begin n_fail++; $display("FAIL hold_data: got %h expected 00000021", rdata_r); end
      act = 0;
      mem_addr = 32'h0; mem_wstrb = 4'hF; mem_valid = 1'b1; mem_myslot = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge mem_clk); #1;
         if (!sram_cen || mem_ready || dbg_state != S_IDLE) act++;
      end
      mem_valid = 1'b0; mem_wstrb = 4'h0;
      n_tests++;
      if (act !== 0) begin n_fail++; $display("FAIL not_myslot: got %0d active cycles expected 0", act); end
   endtask

   task automatic test_valid_drop();
      run_req(32'h0000_0008, 32'hA5A5_5A5A, 4'hF, -1);
      n_tests++;
      if (rdy_n !== 1 || wen_n !== 2) begin
         n_fail++; $display("FAIL drop_complete: got rdy=%0d wen=%0d expected 1 2", rdy_n, wen_n);
      end
      n_tests++;
      if (mem[2] !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL drop_model: got %h expected a5a55a5a", mem[2]); end
   endtask

   task automatic test_parity();
      logic exp_perr;
`ifdef NUBUS_SRAM_PARITY_EN
      exp_perr = 1'b1;
`else
      exp_perr = 1'b0;
`endif
      flip_p2 = 1'b1;
      run_req(32'hF000_0000, 32'h0, 4'h0, 0);
      flip_p2 = 1'b0;
      n_tests++;
      if (rdy_n !== 1 || perr_r !== exp_perr) begin
         n_fail++; $display("FAIL parity_flip: got rdy=%0d perr=%b expected 1 %b", rdy_n, perr_r, exp_perr);
      end
      n_tests++;
      if (mem_parerr !== 1'b0) begin n_fail++; $display("FAIL parity_clear: got %b expected 0", mem_parerr); end
   endtask

   task automatic test_reset_mid();
      mem_addr = 32'h0000_000C; mem_wdata = 32'h1234_5678; mem_wstrb = 4'hF;
      mem_myslot = 1'b1; mem_valid = 1'b1;
      @(posedge mem_clk); #1;
      @(posedge mem_clk); #1;
      n_tests++;
      if (sram_wen !== 1'b0 || dbg_state !== S_ACCESS) begin
         n_fail++; $display("FAIL rst_mid_pre: got wen=%b state=%0d expected 0 %0d", sram_wen, dbg_state, S_ACCESS);
      end
      mem_reset = 1'b1;
      @(posedge mem_clk); #1;
      n_tests++;
      if ({sram_wen, sram_cen, sram_dq_oe, mem_ready} !== 4'b1100 || dbg_state !== S_IDLE) begin
         n_fail++; $display("FAIL rst_mid: got wen/cen/oe/rdy=%b state=%0d expected 1100 %0d",
                            {sram_wen, sram_cen, sram_dq_oe, mem_ready}, dbg_state, S_IDLE);
      end
      mem_reset = 1'b0; mem_valid = 1'b0; mem_myslot = 1'b0; mem_wstrb = 4'h0;
      @(posedge mem_clk); #1;
      n_tests++;
      if (mem_ready !== 1'b0 || sram_cen !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_after: got rdy=%b cen=%b expected 0 1", mem_ready, sram_cen);
      end
   endtask

   initial begin
      repeat (3) @(posedge mem_clk);
      #1;
      test_reset();
      mem_reset = 1'b0;
      @(posedge mem_clk); #1;
      test_write();
      test_read();
      test_byte_write();
      test_hold_valid();
      test_valid_drop();
      test_parity();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/nubus_sram_ctrl.md
NUBUS_SRAM_CTRL -- requirements
Module: nubus_sram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 18: SRAM word-address width.
REQ-002 SHALL have parameter WAIT_RD, default 2: read ACCESS cycles, legal range 1..15.
REQ-003 SHALL have parameter WAIT_WR, default 2: write ACCESS cycles, legal range 1..15.
REQ-004 SHALL have port mem_clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port mem_reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports mem_valid in 1, mem_addr in 32, mem_wdata in 32, mem_wstrb in 4, mem_myslot in 1, mem_myexp in 1: request from the NuBus slave interface.
REQ-007 SHALL have ports mem_ready out 1, mem_rdata out 32, mem_parerr out 1: response to the slave interface.
REQ-008 SHALL have SRAM ports: sram_addr out ADDR_W; sram_dq_o out 32; sram_dq_i in 32; sram_dq_oe out 1; sram_dqp_o out 4; sram_dqp_i in 4; sram_cen, sram_wen, sram_oen out 1 (active-low); sram_ben out 4 (active-low).

Function
REQ-009 SHALL accept a request in IDLE only when mem_valid=1 and mem_myslot=1; mem_myexp is ignored.
REQ-010 SHALL treat mem_wstrb=0 as a read (sram_ben=0000) and mem_wstrb≠0 as a write (sram_ben=~mem_wstrb).
REQ-011 SHALL register mem_addr[ADDR_W+1:2] into sram_addr at acceptance; higher address bits alias.
REQ-012 SHALL implement states IDLE→SETUP→ACCESS→DONE→RELEASE→IDLE, one cycle each except ACCESS.
REQ-013 SHALL hold ACCESS for exactly WAIT_RD (read) or WAIT_WR (write) cycles, counted by a 4-bit down-counter.
REQ-014 SHALL assert mem_ready for exactly one cycle, in DONE; for a request sampled at edge 0, that is edge WAIT+2.
REQ-015 SHALL stay in RELEASE until mem_valid=0, so one held request never produces two accesses.
REQ-016 SHALL drive sram_cen=0 from SETUP through DONE, and sram_oen=0 from SETUP through DONE for reads only.
REQ-017 SHALL drive sram_wen=0 only during ACCESS of writes, with sram_dq_oe=1 and sram_dq_o=mem_wdata from SETUP through DONE.
REQ-018 SHALL capture sram_dq_i into mem_rdata on the last ACCESS cycle of a read; mem_rdata holds that value until the next read.
REQ-019 SHALL complete an SRAM cycle already in progress if mem_valid drops mid-access, and still pulse mem_ready.
REQ-020 SHALL never allow sram_wen=0 while sram_oen=0, nor sram_dq_oe=1 while sram_oen=0.

Reset
REQ-021 SHALL, on mem_reset=1 at any state including mid-access, enter IDLE on the next edge.
REQ-022 The same reset SHALL set: mem_ready=0, mem_parerr=0, mem_rdata=0; sram_cen, sram_wen, sram_oen=1; sram_ben=1111; sram_dq_oe=0; sram_addr=0; sram_dq_o=0; sram_dqp_o=0.

Configuration
REQ-023 With NUBUS_SRAM_PARITY_EN defined, sram_dqp_o[i] SHALL be the even parity of written byte i.
REQ-024 With NUBUS_SRAM_PARITY_EN defined, a read SHALL check all 4 bytes against sram_dqp_i and set mem_parerr=1 with mem_ready on any mismatch.
REQ-025 Without NUBUS_SRAM_PARITY_EN, all ports SHALL remain present, sram_dqp_o SHALL be 0, sram_dqp_i SHALL be ignored, and mem_parerr SHALL be constant 0.

Structure
REQ-026 Package nubus_sram_pkg SHALL hold the state enum, default WAIT_RD/WAIT_WR constants, and the ACCESS counter width.
REQ-027 Per-byte parity generate/check SHALL be one sub-module, nubus_sram_parity, instantiated only under NUBUS_SRAM_PARITY_EN.

Verification
REQ-028 Write F0000000/87654321, wstrb 1111, WAIT_WR=2 -> sram_wen low for 2 cycles; mem_ready at edge 4; sram_addr=0.
REQ-029 Read F0000000, model returns 87654321 -> mem_rdata=87654321 and mem_ready at edge 4; sram_oen low SETUP..DONE, sram_wen high throughout.
REQ-030 Write F0000004, wstrb 0001, then read back -> sram_ben=1110 during write; readback low byte 21, others 00 (model cleared).
REQ-031 Hold mem_valid high 10 cycles after mem_ready -> exactly one SRAM cycle and one mem_ready pulse; mem_myslot=0 -> no SRAM activity.
REQ-032 Assert mem_reset during ACCESS of a write -> next edge: sram_wen=1, sram_cen=1, sram_dq_oe=0, state IDLE, no mem_ready.
REQ-033 With parity enabled, read where model flips sram_dqp_i[2] -> mem_parerr=1 coincident with mem_ready; without the macro, mem_parerr stays 0.
